// File: rtl/segment_sampler.sv
// Proposes a signed value in [from, to]: uniform, or biased high/low via the max/min of K draws.
// A Galois LFSR feeds masked candidates, and each out-of-range candidate is rejected and redrawn a bounded number of times.
module segment_sampler #(
    parameter int WIDTH     = 8,
    parameter int LFSR_W    = 16,
    parameter int MAX_DRAWS = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_enable,
    input  logic                    in_seed_load,
    input  logic [LFSR_W-1:0]       in_seed,
    input  logic                    in_start,
    input  logic signed [WIDTH-1:0] in_from,
    input  logic signed [WIDTH-1:0] in_to,
    input  logic [1:0]              in_chosen_segment_type,
    input  logic signed [WIDTH-1:0] in_chosen_segment_weight,
    output logic                    out_busy,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_proposed_value,
    output logic                    out_error,
    output logic                    out_fallback
);

    localparam int RW = WIDTH + 1;
    localparam int DW = $clog2(MAX_DRAWS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    typedef enum logic {S_IDLE, S_DRAW} state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // Smear the top set bit downward: smallest all-ones value that covers r.
    function automatic logic [RW-1:0] fill_mask(input logic [RW-1:0] r);
        logic [RW-1:0] m;
        m = r;
        for (int i = 0; i < RW; i++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] clamp_draws(input logic signed [WIDTH-1:0] w);
        if (w < 1) begin
            return DW'(1);
        end else if (w > MAX_DRAWS) begin
            return DW'(MAX_DRAWS);
        end else begin
            return DW'(w);
        end
    endfunction

    state_t                  state_q, state_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic [DW-1:0]           draws_q, draws_d;
    logic [TW-1:0]           tries_q, tries_d;
    logic                    fallback_q, fallback_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_value_q, out_value_d;
    logic                    out_error_q, out_error_d;
    logic                    out_fallback_q, out_fallback_d;

    logic signed [WIDTH-1:0] from_q, from_d;
    logic [1:0]              type_q, type_d;
    logic [DW-1:0]           k_q, k_d;
    logic [RW-1:0]           range_q, range_d;
    logic [RW-1:0]           mask_q, mask_d;
    logic [RW-1:0]           best_q, best_d;

    logic signed [RW-1:0]    from_ext, to_ext, span;
    logic                    start_err;
    logic [LFSR_W-1:0]       lfsr_next;
    logic [RW-1:0]           cand, pick, merged;
    logic                    cand_ok, last_try, take;
    logic [DW-1:0]           draws_inc;

    assign from_ext  = {in_from[WIDTH-1], in_from};
    assign to_ext    = {in_to[WIDTH-1], in_to};
    assign span      = to_ext - from_ext;
    assign start_err = (in_chosen_segment_type == 2'd0) || (in_to < in_from);

    assign lfsr_next = lfsr_step(lfsr_q);
    assign cand      = lfsr_next[RW-1:0] & mask_q;
    assign cand_ok   = cand <= range_q;
    assign last_try  = tries_q == TW'(MAX_TRIES - 1);
    assign take      = cand_ok || last_try;
    // Halving a masked candidate always lands inside the range, so the fallback never rejects.
    assign pick      = cand_ok ? cand : (cand >> 1);
    assign draws_inc = draws_q + DW'(1);

    always_comb begin
        merged = pick;
        if (draws_q != '0) begin
            if (type_q == 2'd2) begin
                merged = (pick > best_q) ? pick : best_q;
            end else begin
                merged = (pick < best_q) ? pick : best_q;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        draws_d        = draws_q;
        tries_d        = tries_q;
        fallback_d     = fallback_q;
        out_valid_d    = 1'b0;
        out_value_d    = out_value_q;
        out_error_d    = out_error_q;
        out_fallback_d = out_fallback_q;
        from_d         = from_q;
        type_d         = type_q;
        k_d            = k_q;
        range_d        = range_q;
        mask_d         = mask_q;
        best_d         = best_q;
        case (state_q)
            S_IDLE: begin
                if (in_seed_load) begin
                    lfsr_d = (in_seed == '0) ? LFSR_W'(1) : in_seed;
                end
                if (in_start) begin
                    if (start_err) begin
                        out_valid_d    = 1'b1;
                        out_error_d    = 1'b1;
                        out_fallback_d = 1'b0;
                        out_value_d    = in_from;
                    end else begin
                        state_d    = S_DRAW;
                        from_d     = in_from;
                        type_d     = in_chosen_segment_type;
                        range_d    = span;
                        mask_d     = fill_mask(span);
                        // A zero-width range needs only one draw whatever the bias.
                        k_d        = (in_chosen_segment_type == 2'd1 || span == '0)
                                     ? DW'(1) : clamp_draws(in_chosen_segment_weight);
                        draws_d    = '0;
                        tries_d    = '0;
                        fallback_d = 1'b0;
                    end
                end
            end
            S_DRAW: begin
                lfsr_d = lfsr_next;
                if (take) begin
                    draws_d    = draws_inc;
                    tries_d    = '0;
                    best_d     = merged;
                    fallback_d = fallback_q | ~cand_ok;
                    if (draws_inc == k_q) begin
                        state_d        = S_IDLE;
                        out_valid_d    = 1'b1;
                        out_value_d    = from_q + merged[WIDTH-1:0];
                        out_error_d    = 1'b0;
                        out_fallback_d = fallback_q | ~cand_ok;
                    end
                end else begin
                    tries_d = tries_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q        <= S_IDLE;
            lfsr_q         <= LFSR_W'(1);
            draws_q        <= '0;
            tries_q        <= '0;
            fallback_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_value_q    <= '0;
            out_error_q    <= 1'b0;
            out_fallback_q <= 1'b0;
        end else if (in_enable) begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            draws_q        <= draws_d;
            tries_q        <= tries_d;
            fallback_q     <= fallback_d;
            out_valid_q    <= out_valid_d;
            out_value_q    <= out_value_d;
            out_error_q    <= out_error_d;
            out_fallback_q <= out_fallback_d;
        end
    end

    // Operand registers are only read in DRAW after being loaded at start, so they carry no reset.
    always_ff @(posedge in_clock) begin
        if (in_enable) begin
            from_q  <= from_d;
            type_q  <= type_d;
            k_q     <= k_d;
            range_q <= range_d;
            mask_q  <= mask_d;
            best_q  <= best_d;
        end
    end

    assign out_busy           = (state_q == S_DRAW);
    assign out_valid          = out_valid_q;
    assign out_proposed_value = out_value_q;
    assign out_error          = out_error_q;
    assign out_fallback       = out_fallback_q;

endmodule

// File: tb/tb_segment_sampler.sv
// Directed bench for segment_sampler: table of seeded samples with hand-derived LFSR results,
// plus sequences for back-to-back, stall, busy-ignore and mid-run reset.
module tb_segment_sampler;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic seed_load;
    logic [15:0] seed;
    logic start;
    logic signed [7:0] from_v, to_v, weight;
    logic [1:0] typ;
    logic busy, valid, err, fb;
    logic signed [7:0] val;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] r_val;
    logic r_err, r_fb, r_busy, r_got;
    int r_lat;

    typedef struct {
        logic [15:0]       seed;
        logic [1:0]        typ;
        logic signed [7:0] from;
        logic signed [7:0] to;
        logic signed [7:0] weight;
        logic signed [7:0] exp_val;
        logic              exp_err;
        logic              exp_fb;
        int                exp_lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    segment_sampler dut (
        .in_clock                 (clk),
        .in_reset                 (rst_n),
        .in_enable                (en),
        .in_seed_load             (seed_load),
        .in_seed                  (seed),
        .in_start                 (start),
        .in_from                  (from_v),
        .in_to                    (to_v),
        .in_chosen_segment_type   (typ),
        .in_chosen_segment_weight (weight),
        .out_busy                 (busy),
        .out_valid                (valid),
        .out_proposed_value       (val),
        .out_error                (err),
        .out_fallback             (fb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where out_valid is seen.
    task automatic run(input logic ld, input logic [15:0] sd, input logic [1:0] ty,
                       input logic signed [7:0] f, input logic signed [7:0] t,
                       input logic signed [7:0] w, input int stall_at, input bit inject);
        seed_load = ld;
        seed      = sd;
        start     = 1'b1;
        typ       = ty;
        from_v    = f;
        to_v      = t;
        weight    = w;
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        r_lat     = 1;
        while (!valid && r_lat < 60) begin
            if (stall_at != 0 && r_lat == stall_at) begin
                en = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    r_lat++;
                end
                en = 1'b1;
            end
            if (inject && r_lat == 2) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed      = 16'h1234;
                from_v    = 8'sd50;
                to_v      = 8'sd60;
                typ       = 2'd3;
            end
            @(posedge clk); #1;
            r_lat++;
            start     = 1'b0;
            seed_load = 1'b0;
        end
        r_got  = valid;
        r_val  = val;
        r_err  = err;
        r_fb   = fb;
        r_busy = busy;
    endtask

    task automatic check_run(input string name, input int ev, input int ee, input int ef, input int el);
        check({name, "_valid"}, int'(r_got), 1);
        check({name, "_value"}, int'(r_val), ev);
        check({name, "_error"}, int'(r_err), ee);
        check({name, "_fallback"}, int'(r_fb), ef);
        check({name, "_latency"}, r_lat, el);
        check({name, "_busy"}, int'(r_busy), 0);
    endtask

    initial begin
        //          seed      typ   from     to       weight   value    err   fb    lat
        vecs[0]  = '{16'h002D, 2'd1, 8'sd0,   8'sd100, 8'sd0,   8'sd22,  1'b0, 1'b0, 2};
        vecs[1]  = '{16'h5A0B, 2'd1, -8'sd10, 8'sd90,  8'sd0,   -8'sd5,  1'b0, 1'b0, 2};
        vecs[2]  = '{16'h0168, 2'd1, -8'sd50, 8'sd100, 8'sd0,   8'sd40,  1'b0, 1'b0, 3};
        vecs[3]  = '{16'hBF62, 2'd1, -8'sd1,  8'sd127, 8'sd0,   8'sd122, 1'b0, 1'b1, 5};
        vecs[4]  = '{16'h002D, 2'd2, -8'sd20, 8'sd80,  8'sd3,   8'sd2,   1'b0, 1'b0, 4};
        vecs[5]  = '{16'h002D, 2'd3, -8'sd20, 8'sd80,  8'sd3,   -8'sd15, 1'b0, 1'b0, 4};
        vecs[6]  = '{16'h002D, 2'd3, -8'sd20, 8'sd80,  -8'sd3,  8'sd2,   1'b0, 1'b0, 2};
        vecs[7]  = '{16'h0001, 2'd2, 8'sd0,   8'sd100, 8'sd20,  8'sd80,  1'b0, 1'b0, 10};
        vecs[8]  = '{16'h0000, 2'd2, 8'sd0,   8'sd100, 8'sd20,  8'sd80,  1'b0, 1'b0, 10};
        vecs[9]  = '{16'h002D, 2'd1, 8'sd0,   8'sd100, 8'sd5,   8'sd22,  1'b0, 1'b0, 2};
        vecs[10] = '{16'h02D0, 2'd1, 8'h80,   8'sd127, 8'sd0,   -8'sd24, 1'b0, 1'b0, 2};
        vecs[11] = '{16'h0168, 2'd3, 8'h80,   8'sd127, 8'sd2,   -8'sd38, 1'b0, 1'b0, 3};
        vecs[12] = '{16'h0001, 2'd1, -8'sd7,  -8'sd7,  8'sd0,   -8'sd7,  1'b0, 1'b0, 2};
        vecs[13] = '{16'h0001, 2'd2, -8'sd7,  -8'sd7,  8'sd4,   -8'sd7,  1'b0, 1'b0, 2};
        vecs[14] = '{16'h0001, 2'd0, 8'sd10,  8'sd20,  8'sd0,   8'sd10,  1'b1, 1'b0, 1};
        vecs[15] = '{16'h0001, 2'd1, 8'sd10,  8'sd5,   8'sd0,   8'sd10,  1'b1, 1'b0, 1};
        vecs[16] = '{16'h0001, 2'd3, 8'sd127, 8'h80,   8'sd2,   8'sd127, 1'b1, 1'b0, 1};
        vecs[17] = '{16'h0168, 2'd2, 8'h80,   8'sd127, 8'sd2,   8'sd52,  1'b0, 1'b0, 3};

        rst_n     = 1'b0;
        en        = 1'b1;
        seed_load = 1'b0;
        seed      = '0;
        start     = 1'b0;
        typ       = 2'd1;
        from_v    = '0;
        to_v      = '0;
        weight    = '0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_value", int'(val), 0);
        check("reset_error", int'(err), 0);
        check("reset_fallback", int'(fb), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run(1'b1, vecs[i].seed, vecs[i].typ, vecs[i].from, vecs[i].to, vecs[i].weight, 0, 1'b0);
            check_run($sformatf("vec%0d", i), int'(vecs[i].exp_val), int'(vecs[i].exp_err),
                      int'(vecs[i].exp_fb), vecs[i].exp_lat);
        end

        // Back-to-back: second start issued in the cycle the first result is valid.
        run(1'b1, 16'h002D, 2'd1, 8'sd0, 8'sd100, 8'sd0, 0, 1'b0);
        check_run("b2b_first", 22, 0, 0, 2);
        run(1'b0, 16'h0000, 2'd1, 8'sd0, 8'sd100, 8'sd0, 0, 1'b0);
        check_run("b2b_second", 11, 0, 0, 2);
        @(posedge clk); #1;
        check("pulse_valid_drops", int'(valid), 0);
        check("pulse_value_held", int'(val), 11);

        // out_valid holds through a stall and drops at the next enabled edge.
        run(1'b0, 16'h0000, 2'd1, 8'sd0, 8'sd100, 8'sd0, 0, 1'b0);
        check_run("hold_run", 5, 0, 0, 2);
        en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("stall_valid_held", int'(valid), 1);
        en = 1'b1;
        @(posedge clk); #1;
        check("stall_valid_drop", int'(valid), 0);

        // Start/seed-load while busy are ignored; a 3-cycle stall only delays the result.
        run(1'b1, 16'h002D, 2'd2, -8'sd20, 8'sd80, 8'sd3, 0, 1'b1);
        check_run("busy_ignore", 2, 0, 0, 4);
        run(1'b1, 16'h002D, 2'd2, -8'sd20, 8'sd80, 8'sd3, 2, 1'b0);
        check_run("stalled", 2, 0, 0, 7);

        // Reset mid-DRAW aborts without a result; LFSR returns to 1.
        seed_load = 1'b1;
        seed      = 16'h0001;
        start     = 1'b1;
        typ       = 2'd2;
        from_v    = 8'sd0;
        to_v      = 8'sd100;
        weight    = 8'sd20;
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_value", int'(val), 0);
        check("abort_error", int'(err), 0);
        check("abort_fallback", int'(fb), 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_valid_in_reset", int'(valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_valid_after", int'(valid), 0);
        check("abort_busy_after", int'(busy), 0);
        run(1'b0, 16'h0000, 2'd2, 8'sd0, 8'sd100, 8'sd20, 0, 1'b0);
        check_run("post_reset_lfsr", 80, 0, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_sampler.md
# segment_sampler

Parametrised, handshaked successor to the single-range sampler in the MCMC constraint-solver datapath. It draws a proposed variable value inside a signed range [from, to], either uniformly (segment type 1) or biased toward the upper or lower end of the segment (types 2 and 3). Bias is produced by taking the max or min of K independent uniform draws, with K taken from the segment weight. The block sits between the segment-selection logic and the Metropolis acceptance stage and replaces the fixed-8-bit, one-value-per-clock sampler.

## Interface
- WIDTH, 8: width of signed range bounds and proposed value.
- LFSR_W, 16: LFSR state width (fixed taps below, so only 16 is legal).
- MAX_DRAWS, 8: upper clamp on K.
- MAX_TRIES, 4: rejection attempts per draw before the fallback is used.
- in_clock  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_enable  input  1  when low, FSM, LFSR and counters hold (stall); outputs hold.
- in_seed_load  input  1  in IDLE, loads in_seed into the LFSR (seed 0 is replaced by 1).
- in_seed  input  LFSR_W  LFSR seed.
- in_start  input  1  request a sample; accepted only in IDLE with in_enable=1.
- in_from, in_to  input  WIDTH signed  range bounds, latched on start.
- in_chosen_segment_type  input  2  1 = uniform, 2 = max-of-K, 3 = min-of-K, 0 = illegal.
- in_chosen_segment_weight  input  WIDTH signed  K = clamp(weight, 1, MAX_DRAWS); ignored for type 1 (K=1).
- out_busy  output  1  high while not IDLE.
- out_valid  output  1  one-cycle pulse: result ready.
- out_proposed_value  output  WIDTH signed  sample; held until the next out_valid.
- out_error  output  1  qualified by out_valid: type 0 or to<from.
- out_fallback  output  1  qualified by out_valid: at least one draw used the fallback.

## Operation
- LFSR: Galois, shift right, feedback mask 16'hB400; steps once per DRAW cycle only.
- Start (IDLE, enable, in_start): latch from, type and K; compute range = to − from in WIDTH+1 bits unsigned; mask = smallest 2^k−1 ≥ range; clear counters; go to DRAW.
- Error case (type 0 or to<from): no DRAW; next edge gives out_valid=1, out_error=1, value=from; back to IDLE.
- range = 0: one DRAW cycle, result = from.
- DRAW, each enabled cycle:
  - step LFSR; cand = next_state[WIDTH:0] & mask.
  - If cand ≤ range: accept.
  - Else if tries = MAX_TRIES−1: accept cand>>1, which is always ≤ range, and set the sticky fallback flag.
  - Else tries++.
- On accept: draws++, tries=0. best = cand on the first draw; otherwise best = max (type 2) or min (type 3).
- When draws reaches K: register out_proposed_value = from + best (fits WIDTH bits), pulse out_valid, return to IDLE.
- in_start while busy is ignored. in_seed_load while busy is ignored.
- in_start and in_seed_load together in IDLE: seed load first; the first DRAW uses the new seed.

## Timing
- Reset values: state IDLE, LFSR=16'h0001, out_busy=0, out_valid=0, out_proposed_value=0, out_error=0, out_fallback=0.
- Reset assertion mid-DRAW aborts immediately; no out_valid is produced.
- Latency with no rejections: out_valid is high in the cycle following the K-th DRAW edge, i.e. K+1 enabled edges after the start edge. Each rejection adds 1 cycle.
- Worst-case latency: K·MAX_TRIES + 1 cycles.
- out_busy drops in the same cycle out_valid rises. A new in_start may be accepted in that cycle (back-to-back throughput of K+1 cycles).
- in_enable low stretches every timing figure by the stalled cycles. out_valid is not re-pulsed during a stall; it stays high until the next enabled edge.

## Test plan
- Reset, seed 16'h0004, type 1, from=0, to=100, 200 starts → every value in [0,100]; latency 2 cycles whenever no rejection occurred; out_error=0.
- Type 2, weight 4, from=−50, to=50, 500 samples → all in range; mean > 0; each sample latency ≥ 5 cycles. Type 3 with the same settings → mean < 0.
- from=to=−7, type 1 → value −7, latency 2. Then from=10, to=5 → out_error=1, value 10, latency 1.
- MAX_TRIES=1, from=0, to=64 (mask 127) → values in [0,64]; out_fallback=1 on at least one sample; no latency above K+1.
- Deassert in_enable for 3 cycles mid-DRAW (type 2, K=3) → result and latency equal the unstalled run plus 3. Pulse reset mid-DRAW → no out_valid, outputs zero.
- Two runs with identical seed and stimulus → identical value sequences. Seed 0 behaves identically to seed 1.
